// File: rtl/apu_dma_arbiter_pkg.sv
// Shared types and constants for the APU DMA arbiter: controller state encoding,
// the OAM data port address and the fixed stall-cycle lengths.
package apu_dma_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_DUMMY = 3'd2,
      ST_ALIGN = 3'd3,
      ST_GET   = 3'd4,
      ST_PUT   = 3'd5
   } dma_state_e;

   localparam logic [15:0] OAM_PORT_ADDR = 16'h2004;

   // Length of the halt handshake and of the get/put phase alignment, in CPU cycles.
   localparam int unsigned HALT_CYCLES  = 1;
   localparam int unsigned ALIGN_CYCLES = 1;

endpackage

// File: rtl/apu_dma_spr_addr.sv
// Sprite DMA source address generator: latched page plus an 8-bit byte index
// that wraps 255->0 at the end of a transfer.
module apu_dma_spr_addr (
   input  logic        CLK,
   input  logic        n_RES,
   input  logic        load_i,
   input  logic [7:0]  page_i,
   input  logic        inc_i,
   output logic [15:0] addr_o,
   output logic        last_o
);

   logic [7:0] page_q;
   logic [7:0] idx_q;

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         page_q <= 8'h00;
         idx_q  <= 8'h00;
      end else if (load_i) begin
         page_q <= page_i;
         idx_q  <= 8'h00;
      end else if (inc_i) begin
         idx_q  <= idx_q + 8'd1;
      end
   end

   assign addr_o = {page_q, idx_q};
   assign last_o = (idx_q == 8'hFF);

endmodule

// File: rtl/apu_dma_arbiter.sv
// APU DMA arbiter: steals CPU read cycles for DPCM sample fetches and, when
// APU_SPRDMA_EN is defined, for the 256-byte sprite (OAM) DMA started by $4014.
module apu_dma_arbiter
   import apu_dma_arbiter_pkg::*;
(
   input  logic        CLK,
   input  logic        n_RES,
   input  logic        CE,
   input  logic        ACLK1,
   input  logic        RnW,
   input  logic        W4014,
   input  logic [7:0]  DB,
   input  logic        DMC_REQ,
   input  logic [15:0] DMC_ADDR,
   output logic        DMC_ACK,
   output logic        RDY,
   output logic [15:0] ADDR,
   output logic        ADDR_EN,
   output logic        RD,
   output logic        W2004,
   output logic [7:0]  SPR_DATA
);

   dma_state_e  state_q, state_d;
   logic        spr_pend_q, spr_pend_d;
   logic        dmc_pend_q, dmc_pend_d;
   logic        put_spr_q, put_spr_d;
   logic        spr_start;
   logic        spr_inc;
   logic        spr_last;
   logic [15:0] spr_addr;

`ifdef APU_SPRDMA_EN
   logic [7:0] spr_data_q;

   // A second $4014 write while a transfer is still pending is dropped.
   assign spr_start = W4014 && !spr_pend_q;

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         spr_data_q <= 8'h00;
      end else if (CE && (state_q == ST_GET) && !dmc_pend_q) begin
         spr_data_q <= DB;
      end
   end

   assign SPR_DATA = spr_data_q;
`else
   logic unused_spr;

   assign spr_start  = 1'b0;
   assign unused_spr = ^{W4014, DB};
   assign SPR_DATA   = 8'h00;
`endif

   apu_dma_spr_addr u_spr_addr (
      .CLK    (CLK),
      .n_RES  (n_RES),
      .load_i (CE && spr_start),
      .page_i (DB),
      .inc_i  (spr_inc),
      .addr_o (spr_addr),
      .last_o (spr_last)
   );

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         state_q    <= ST_IDLE;
         spr_pend_q <= 1'b0;
         dmc_pend_q <= 1'b0;
         put_spr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         spr_pend_q <= spr_pend_d;
         dmc_pend_q <= dmc_pend_d;
         put_spr_q  <= put_spr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      spr_pend_d = spr_pend_q;
      dmc_pend_d = dmc_pend_q;
      put_spr_d  = put_spr_q;
      spr_inc    = 1'b0;
      if (CE) begin
         if (spr_start) spr_pend_d = 1'b1;
         if (DMC_REQ)   dmc_pend_d = 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (spr_pend_d || dmc_pend_d) state_d = ST_HALT;
            end
            ST_HALT: begin
               // Only a CPU read cycle may be stolen.
               if (RnW) begin
                  if (spr_pend_d) state_d = ACLK1 ? ST_GET : ST_ALIGN;
                  else            state_d = ST_DUMMY;
               end
            end
            ST_DUMMY: state_d = ACLK1 ? ST_GET : ST_ALIGN;
            ST_ALIGN: state_d = ST_GET;
            ST_GET: begin
               put_spr_d = !dmc_pend_q;
               // The acknowledge cycle's own request level is not a new request.
               if (dmc_pend_q) dmc_pend_d = 1'b0;
               state_d = spr_pend_d ? ST_PUT : ST_IDLE;
            end
            ST_PUT: begin
               if (put_spr_q) begin
                  spr_inc = 1'b1;
                  if (spr_last) spr_pend_d = 1'b0;
               end
               state_d = (spr_pend_d || dmc_pend_d) ? ST_GET : ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      RDY     = (state_q == ST_IDLE);
      ADDR    = 16'h0000;
      ADDR_EN = 1'b0;
      RD      = 1'b0;
      W2004   = 1'b0;
      DMC_ACK = 1'b0;
      case (state_q)
         ST_GET: begin
            RD      = 1'b1;
            ADDR_EN = 1'b1;
            if (dmc_pend_q) begin
               ADDR    = DMC_ADDR;
               DMC_ACK = 1'b1;
            end else begin
               ADDR    = spr_addr;
            end
         end
         ST_PUT: begin
            // A put following a DPCM get is an idle bus cycle.
            if (put_spr_q) begin
               W2004   = 1'b1;
               ADDR    = OAM_PORT_ADDR;
               ADDR_EN = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/apu_dma_arbiter.md
APU_DMA_ARBITER -- requirements
Module: apu_dma_arbiter

Interface
REQ-001 CLK  in  1  master clock; all state changes on rising edge.
REQ-002 n_RES  in  1  asynchronous, active-low reset.
REQ-003 CE  in  1  one-CLK strobe per CPU cycle; state advances only when CE=1.
REQ-004 ACLK1  in  1  APU phase: 1 = get (read) cycle, 0 = put (write) cycle.
REQ-005 RnW  in  1  CPU read/write of the current cycle (1 = read).
REQ-006 W4014  in  1  sprite-DMA start strobe; DB carries the source page.
REQ-007 DB  in  8  data bus: page on W4014, fetched byte on DMA reads.
REQ-008 DMC_REQ  in  1  level request from the DPCM channel for one sample byte.
REQ-009 DMC_ADDR  in  16  DPCM sample address.
REQ-010 DMC_ACK  out  1  one-CPU-cycle pulse; DB holds the DPCM byte.
REQ-011 RDY  out  1  CPU ready; 0 stalls the CPU.
REQ-012 ADDR  out  16  DMA address; ADDR_EN  out  1  arbiter owns the bus.
REQ-013 RD  out  1  DMA read cycle; W2004  out  1  OAM write cycle; SPR_DATA  out  8  byte written to OAM.

Function
REQ-014 States: IDLE, HALT, DUMMY, ALIGN, GET, PUT; transitions only on CE=1.
REQ-015 IDLE: RDY=1, ADDR_EN=0; W4014 latches page=DB and sets spr_pend; DMC_REQ=1 sets dmc_pend.
REQ-016 Any pending in IDLE -> HALT with RDY=0 the next cycle; RDY stays 0 until all pending work is done.
REQ-017 HALT exits only when RnW=1 is sampled; RnW=0 keeps HALT (CPU write cycles are never stolen).
REQ-018 After HALT: dmc_pend only -> DUMMY (one idle cycle) -> GET if ACLK1=1, else ALIGN then GET.
REQ-019 After HALT with spr_pend -> GET if ACLK1=1, else ALIGN then GET; no DUMMY.
REQ-020 GET: RD=1, ADDR_EN=1; dmc_pend wins -> ADDR=DMC_ADDR, DMC_ACK=1, clear dmc_pend; else ADDR={page,idx}, SPR_DATA<=DB.
REQ-021 PUT: after a sprite GET -> W2004=1, ADDR=16'h2004, ADDR_EN=1, idx+=1 (8-bit); after a DMC GET in sprite mode -> one idle put, no OAM write.
REQ-022 Sprite transfer ends after the PUT with idx wrapping 255->0; spr_pend cleared.
REQ-023 Nothing pending after GET/PUT -> IDLE, RDY=1 the following cycle.
REQ-024 Standalone sprite DMA holds RDY=0 for 513 or 514 CPU cycles; standalone DMC fetch for 3 or 4.
REQ-025 DMC_REQ during a sprite DMA steals the next GET and delays the sprite by exactly 2 cycles.
REQ-026 W4014 while spr_pend=1 is ignored; DMC_REQ held high after DMC_ACK queues a new fetch.
REQ-027 ADDR=0, RD=0, W2004=0 and DMC_ACK=0 in IDLE, HALT, DUMMY and ALIGN.

Reset
REQ-028 n_RES=0 forces IDLE, clears page, idx, SPR_DATA and both pendings; RDY=1, all other outputs 0.
REQ-029 Reset during any DMA abandons it with no further OAM writes and no DMC_ACK.

Configuration
REQ-030 APU_SPRDMA_EN defined: sprite DMA path as specified.
REQ-031 APU_SPRDMA_EN undefined: W4014 ignored, W2004=0, SPR_DATA=0, only the DMC flow exists.

Structure
REQ-032 Shared package: state enum, OAM_PORT_ADDR=16'h2004, HALT/ALIGN cycle constants.
REQ-033 Single module; the 8-bit index/page address generator may be split out as apu_dma_spr_addr.

Verification
REQ-034 W4014 with DB=8'h02, ACLK1=1 at HALT exit -> reads 16'h0200..16'h02FF, 256 W2004 pulses, RDY low for 513 cycles.
REQ-035 Same as REQ-034 with ACLK1=0 at HALT exit -> one ALIGN cycle, RDY low for 514 cycles.
REQ-036 DMC_REQ with DMC_ADDR=16'hC000 in IDLE -> HALT, DUMMY, (ALIGN), GET at 16'hC000 with DMC_ACK, RDY low for 3 or 4 cycles.
REQ-037 DMC_REQ during sprite byte idx=8'h10 -> the next GET reads DMC_ADDR, then sprite resumes at idx 8'h10, total RDY-low time +2.
REQ-038 RnW=0 for 3 cycles in HALT -> stays in HALT, no bus cycles, exits on the first RnW=1.
REQ-039 n_RES=0 at idx=8'h80 -> RDY=1 and all outputs 0 immediately; no W2004 after release.
